// File: rtl/add_subb_serial_pkg.sv
// Shared types and constants for the chunk-serial add/subtract unit.
// Holds the FSM state encoding, the inter-chunk carry width and the counter sizing helper.
package add_subb_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two negated operands can push the running carry up to 2.
    localparam int CW = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_subb_serial_chunk.sv
// One W-bit slice of the serial adder: optional inversion of each operand plus a 2-bit carry in.
// The widened sum exposes carries up to 2, which occur when both operands are inverted.
module add_subb_serial_chunk
    import add_subb_serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          subb_a,
    input  logic          subb_b,
    input  logic [CW-1:0] cin,
    output logic [W-1:0]  s,
    output logic [CW-1:0] cout
);

    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W+CW-1:0] sum;

    assign a_sel = subb_a ? ~a : a;
    assign b_sel = subb_b ? ~b : b;
    assign sum   = {{CW{1'b0}}, a_sel} + {{CW{1'b0}}, b_sel} + {{W{1'b0}}, cin};

    assign s    = sum[W-1:0];
    assign cout = sum[W+CW-1:W];

endmodule

// File: rtl/add_subb_serial.sv
// Chunk-serial signed add/subtract: s = (+/-a) + (+/-b) mod 2^(N*W), one W-bit chunk per clock, LSB first.
// Operands are captured on the accept edge; the result is held on a valid/ready port until taken.
module add_subb_serial
    import add_subb_serial_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           subb_a,
    input  logic           subb_b,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] s,
    output logic           c
);

    localparam int NW = N * W;
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t state;
    state_t state_next;

    logic [NW-1:0] a_reg;
    logic [NW-1:0] b_reg;
    logic [NW-1:0] s_reg;
    logic          subb_a_reg;
    logic          subb_b_reg;
    logic [IW-1:0] idx;
    logic [CW-1:0] carry;
    logic          c_reg;

    logic [W-1:0]  chunk_a;
    logic [W-1:0]  chunk_b;
    logic [W-1:0]  chunk_s;
    logic [CW-1:0] chunk_cout;

    logic accept;
    logic release_out;
    logic last_chunk;

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign last_chunk  = (idx == LAST_IDX);

    assign chunk_a = a_reg[int'(idx) * W +: W];
    assign chunk_b = b_reg[int'(idx) * W +: W];

    add_subb_serial_chunk #(
        .W (W)
    ) u_chunk (
        .a      (chunk_a),
        .b      (chunk_b),
        .subb_a (subb_a_reg),
        .subb_b (subb_b_reg),
        .cin    (carry),
        .s      (chunk_s),
        .cout   (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)      state_next = ST_RUN;
            ST_RUN:  if (last_chunk)  state_next = ST_DONE;
            ST_DONE: if (release_out) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Seeding the carry with the negate flags completes the two's complement of inverted operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            subb_a_reg <= 1'b0;
            subb_b_reg <= 1'b0;
            idx        <= '0;
            carry      <= '0;
            c_reg      <= 1'b0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            subb_a_reg <= subb_a;
            subb_b_reg <= subb_b;
            idx        <= '0;
            carry      <= CW'(subb_a) + CW'(subb_b);
        end else if (state == ST_RUN) begin
            s_reg[int'(idx) * W +: W] <= chunk_s;
            carry                     <= chunk_cout;
            idx                       <= idx + IW'(1);
            if (last_chunk) begin
                c_reg <= |chunk_cout;
            end
        end
    end

    assign s = s_reg;
    assign c = c_reg;

endmodule

// File: tb/tb_add_subb_serial.sv
// Self-checking bench for add_subb_serial at W=8, N=4: table of directed vectors plus
// hand-written backpressure and mid-run reset sequences.
module tb_add_subb_serial;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NW = W * N;

    typedef struct {
        logic [NW-1:0] a;
        logic [NW-1:0] b;
        logic          sa;
        logic          sb;
        logic [NW-1:0] exp_s;
        logic          exp_c;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          subb_a;
    logic          subb_b;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] s;
    logic          c;

    int checks;
    int failures;

    vec_t vecs[9];

    add_subb_serial #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .subb_a    (subb_a),
        .subb_b    (subb_b),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one transaction at a negedge; returns at the negedge just after the accept edge,
    // with the inputs scrambled so that any late sampling corrupts the result.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        a        = v.a;
        b        = v.b;
        subb_a   = v.sa;
        subb_b   = v.sb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        subb_a   = 1'($urandom);
        subb_b   = 1'($urandom);
    endtask

    task automatic waitResult(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            checkOutput({name, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(N));
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, "_out_valid_after_release"}, 64'(out_valid), 64'd0);
        checkOutput({name, "_in_ready_after_release"}, 64'(in_ready), 64'd1);
    endtask

    task automatic runVector(input vec_t v, input string name);
        applyStimulus(v);
        waitResult(name);
        checkOutput({name, "_s"}, 64'(s), 64'(v.exp_s));
        checkOutput({name, "_c"}, 64'(c), 64'(v.exp_c));
        releaseResult(name);
    endtask

    initial begin
        vec_t v;
        logic [NW-1:0] held_s;
        logic          held_c;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        subb_a    = 1'b0;
        subb_b    = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1};
        vecs[4] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0010, 32'h0000_0030, 1'b1, 1'b0, 32'h0000_0020, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_s", 64'(s), 64'd0);
        checkOutput("reset_c", 64'(c), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for three cycles while in_valid pulses are offered.
        applyStimulus(vecs[7]);
        waitResult("bp");
        held_s = s;
        held_c = c;
        checkOutput("bp_s", 64'(held_s), 64'(vecs[7].exp_s));
        for (int k = 0; k < 3; k++) begin
            in_valid = k[0];
            a        = 32'hDEAD_BEEF;
            b        = 32'h0BAD_F00D;
            @(negedge clk);
            checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            checkOutput("bp_s_stable", 64'(s), 64'(vecs[7].exp_s));
            checkOutput("bp_c_stable", 64'(c), 64'(vecs[7].exp_c));
        end
        in_valid = 1'b0;
        releaseResult("bp");
        @(negedge clk);
        checkOutput("bp_no_phantom_start", 64'(in_ready), 64'd1);

        // Reset asserted during the second RUN cycle drops the work in flight.
        applyStimulus(vecs[1]);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_s", 64'(s), 64'd0);
        checkOutput("midrst_c", 64'(c), 64'd0);
        repeat (N + 2) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        v = vecs[4];
        runVector(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
